matmul_sequencer: RTL

Control sequencer for the execute-stage matrix unit. Accepts one matrix-multiply command from the pipeline, streams the A and B operand tiles from data memory into the matrix unit, starts the multiply, then drains the C result tile back to memory. Holds the pipeline stalled for the duration. It is the sole master of the matrix unit's write-enable, row/col and start controls.

---
 rtl/matseq_pkg.sv | 10 +
 rtl/mat_index_ctr.sv | 21 ++
 rtl/matmul_sequencer.sv | 114 +++++++++++
 3 files changed

// File: rtl/matseq_pkg.sv
// matseq_pkg: state encoding, element addressing constant and DIM legality check for the sequencer
package matseq_pkg;
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_A, S_LOAD_B, S_START, S_WAIT, S_DRAIN_RD, S_DRAIN_WR, S_DONE
    } state_e;
    localparam int ELEM_SHIFT = 2;
    function automatic bit dim_ok(input int d);
        return d >= 2 && d <= 16 && (d & (d - 1)) == 0;
    endfunction
endpackage

// File: rtl/mat_index_ctr.sv
// mat_index_ctr: row-major tile index counter; {row,col} wraps naturally since DIM is a power of two
module mat_index_ctr #(
    parameter int IDX_W = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [IDX_W-1:0] row_o,
    output logic [IDX_W-1:0] col_o,
    output logic             last_o
);
    logic [2*IDX_W-1:0] idx_q, idx_d;
    always_comb idx_d = clr_i ? '0 : en_i ? idx_q + (2*IDX_W)'(1) : idx_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) idx_q <= '0;
        else idx_q <= idx_d;
    end
    assign {row_o, col_o} = idx_q;
    assign last_o = &idx_q;
endmodule

// File: rtl/matmul_sequencer.sv
// matmul_sequencer: loads A/B tiles into the matrix unit, starts it, drains C back to memory
module matmul_sequencer
    import matseq_pkg::*;
#(
    parameter int DIM    = 4,
    parameter int DATA_W = 32,
    parameter int IDX_W  = $clog2(DIM)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [31:0]       cmd_a_base_i,
    input  logic [31:0]       cmd_b_base_i,
    input  logic [31:0]       cmd_c_base_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [31:0]       mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              mxu_we_a_o,
    output logic              mxu_we_b_o,
    output logic [IDX_W-1:0]  mxu_row_o,
    output logic [IDX_W-1:0]  mxu_col_o,
    output logic [DATA_W-1:0] mxu_data_o,
    output logic              mxu_start_o,
    input  logic              mxu_done_i,
    input  logic [DATA_W-1:0] mxu_cout_i
);
    state_e state_q, state_d;
    logic [31:0] a_base_q, a_base_d, b_base_q, b_base_d, c_base_q, c_base_d;
    logic [DATA_W-1:0] cdata_q, cdata_d;
    logic [IDX_W-1:0] row, col;
    logic last, load, drain_rd, drain_wr, idx_live, accept, step;
    logic [31:0] base, addr;

    if (!dim_ok(DIM)) begin : g_dim_check
        $error("matmul_sequencer: DIM must be a power of two in 2..16");
    end

    // an ack that coincides with abort is consumed but must not move the index
    assign step = mem_req_o && mem_ack_i && !abort_i;

    mat_index_ctr #(.IDX_W(IDX_W)) u_idx (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (state_q == S_IDLE),
        .en_i   (step),
        .row_o  (row),
        .col_o  (col),
        .last_o (last)
    );

    assign load     = state_q == S_LOAD_A || state_q == S_LOAD_B;
    assign drain_rd = state_q == S_DRAIN_RD;
    assign drain_wr = state_q == S_DRAIN_WR;
    assign idx_live = load || drain_rd || drain_wr;
    assign accept   = state_q == S_IDLE && cmd_valid_i;
    assign base     = state_q == S_LOAD_A ? a_base_q : state_q == S_LOAD_B ? b_base_q : c_base_q;
    assign addr     = base + (32'({row, col}) << ELEM_SHIFT);

    always_comb begin
        a_base_d = accept ? cmd_a_base_i : a_base_q;
        b_base_d = accept ? cmd_b_base_i : b_base_q;
        c_base_d = accept ? cmd_c_base_i : c_base_q;
        cdata_d  = drain_rd ? mxu_cout_i : cdata_q;
        state_d  = state_q;
        case (state_q)
            S_IDLE:     state_d = cmd_valid_i ? S_LOAD_A : S_IDLE;
            S_LOAD_A:   state_d = mem_ack_i && last ? S_LOAD_B : S_LOAD_A;
            S_LOAD_B:   state_d = mem_ack_i && last ? S_START : S_LOAD_B;
            S_START:    state_d = S_WAIT;
            S_WAIT:     state_d = mxu_done_i ? S_DRAIN_RD : S_WAIT;
            S_DRAIN_RD: state_d = S_DRAIN_WR;
            S_DRAIN_WR: state_d = mem_ack_i ? (last ? S_DONE : S_DRAIN_RD) : S_DRAIN_WR;
            default:    state_d = S_IDLE;
        endcase
        if (abort_i && state_q != S_IDLE) state_d = S_IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            a_base_q <= '0;
            b_base_q <= '0;
            c_base_q <= '0;
            cdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            a_base_q <= a_base_d;
            b_base_q <= b_base_d;
            c_base_q <= c_base_d;
            cdata_q  <= cdata_d;
        end
    end

    assign cmd_ready_o = state_q == S_IDLE;
    assign busy_o      = state_q != S_IDLE;
    assign done_o      = state_q == S_DONE && !abort_i;
    assign mem_req_o   = load || drain_wr;
    assign mem_we_o    = drain_wr;
    assign mem_addr_o  = mem_req_o ? addr : '0;
    assign mem_wdata_o = drain_wr ? cdata_q : '0;
    assign mxu_we_a_o  = state_q == S_LOAD_A && mem_ack_i;
    assign mxu_we_b_o  = state_q == S_LOAD_B && mem_ack_i;
    assign mxu_data_o  = load && mem_ack_i ? mem_rdata_i : '0;
    assign mxu_row_o   = idx_live ? row : '0;
    assign mxu_col_o   = idx_live ? col : '0;
    assign mxu_start_o = state_q == S_START;
endmodule
